ack_stream_merger: RTL and testbench

ACK_STREAM_MERGER -- requirements
Module: ack_stream_merger

---
 rtl/ack_stream_merger.sv | 155 +++++++++++++++
 tb/tb_ack_stream_merger.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ack_stream_merger.sv
`default_nettype none
// ============================================================================
// Module   : ack_stream_merger
// Brief    : Round-robin, packet-atomic merger of NUM_CH AXI-Stream ack
//            streams into one registered output stream.
//            Optional per-channel packet counters: define MERGER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ack_stream_merger #(
    parameter int NUM_CH   = 4,
    parameter int MAX_ACCS = 16,
    parameter int DATA_W   = 64,
    parameter int TDEST_W  = $clog2(MAX_ACCS),
    parameter int CH_W     = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_CH-1:0]         s_tvalid,
    output logic [NUM_CH-1:0]         s_tready,
    input  logic [NUM_CH*TDEST_W-1:0] s_tdest,
    input  logic [NUM_CH*DATA_W-1:0]  s_tdata,
    input  logic [NUM_CH-1:0]         s_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [TDEST_W-1:0]        m_tdest,
    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_tlast,
    output logic [CH_W-1:0]           m_tsrc
`ifdef MERGER_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]      pkt_cnt
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CH_W-1:0]   r_grant;
    logic [CH_W-1:0]   w_grant_nxt;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   w_rr_nxt;
    logic [CH_W-1:0]   w_pick;
    logic              w_out_free;
    logic              w_acc;
    logic              w_last;

    logic              r_m_tvalid;
    logic [TDEST_W-1:0] r_m_tdest;
    logic [DATA_W-1:0] r_m_tdata;
    logic              r_m_tlast;
    logic [CH_W-1:0]   r_m_tsrc;

    function automatic logic [CH_W-1:0] f_wrap(input int v);
        f_wrap = CH_W'(v % NUM_CH);
    endfunction

    // Scan from lowest priority to highest so the channel nearest rr_ptr wins.
    always_comb begin
        w_pick = r_rr_ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (s_tvalid[f_wrap(int'(r_rr_ptr) + i)]) begin
                w_pick = f_wrap(int'(r_rr_ptr) + i);
            end
        end
    end

    assign w_out_free = !r_m_tvalid || m_tready;
    assign w_acc      = (r_state == LOCK) && s_tvalid[r_grant] && w_out_free;
    assign w_last     = s_tlast[r_grant];

    always_comb begin
        s_tready = '0;
        if (r_state == LOCK) begin
            s_tready[r_grant] = w_out_free;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (|s_tvalid) begin
                    w_state_nxt = LOCK;
                    w_grant_nxt = w_pick;
                end
            end
            LOCK: begin
                if (w_acc && w_last) begin
                    w_state_nxt = IDLE;
                    w_rr_nxt    = (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + CH_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // Output holding register: loads on input acceptance, clears on drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m_tvalid <= 1'b0;
            r_m_tdest  <= '0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tsrc   <= '0;
        end else if (w_acc) begin
            r_m_tvalid <= 1'b1;
            r_m_tdest  <= s_tdest[r_grant*TDEST_W +: TDEST_W];
            r_m_tdata  <= s_tdata[r_grant*DATA_W +: DATA_W];
            r_m_tlast  <= w_last;
            r_m_tsrc   <= r_grant;
        end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_tvalid = r_m_tvalid;
    assign m_tdest  = r_m_tdest;
    assign m_tdata  = r_m_tdata;
    assign m_tlast  = r_m_tlast;
    assign m_tsrc   = r_m_tsrc;

`ifdef MERGER_STATS_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_pkt_cnt
        logic [31:0] r_cnt;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_cnt <= '0;
            end else if (w_acc && w_last && (r_grant == CH_W'(i))) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
        assign pkt_cnt[i*32 +: 32] = r_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ack_stream_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_ack_stream_merger
// Brief    : Scoreboard bench for ack_stream_merger (stats with MERGER_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ack_stream_merger;

    localparam int NUM_CH   = 4;
    localparam int MAX_ACCS = 16;
    localparam int DATA_W   = 64;
    localparam int TDEST_W  = 4;
    localparam int CH_W     = 2;

    logic                      clk = 1'b0;
    logic                      rstn = 1'b0;
    logic [NUM_CH-1:0]         s_tvalid;
    logic [NUM_CH-1:0]         s_tready;
    logic [NUM_CH*TDEST_W-1:0] s_tdest;
    logic [NUM_CH*DATA_W-1:0]  s_tdata;
    logic [NUM_CH-1:0]         s_tlast;
    logic                      m_tvalid;
    logic                      m_tready;
    logic [TDEST_W-1:0]        m_tdest;
    logic [DATA_W-1:0]         m_tdata;
    logic                      m_tlast;
    logic [CH_W-1:0]           m_tsrc;
`ifdef MERGER_STATS_EN
    logic [NUM_CH*32-1:0]      pkt_cnt;
`endif

    ack_stream_merger #(
        .NUM_CH(NUM_CH), .MAX_ACCS(MAX_ACCS), .DATA_W(DATA_W),
        .TDEST_W(TDEST_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdest(s_tdest),
        .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdest(m_tdest),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tsrc(m_tsrc)
`ifdef MERGER_STATS_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TDEST_W-1:0] dest;
        logic [DATA_W-1:0]  data;
        logic               last;
    } src_beat_t;

    typedef struct packed {
        logic [CH_W-1:0]    src;
        logic [TDEST_W-1:0] dest;
        logic [DATA_W-1:0]  data;
        logic               last;
    } out_beat_t;

    src_beat_t   src_q [NUM_CH][$];
    out_beat_t   exp_q [$];
    logic [31:0] mdl_cnt [NUM_CH];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          out_cnt, first_cyc, rise_cyc, prev_out_cyc;
    bit          seen_valid, have_prev, chk_gap;
    logic [NUM_CH-1:0] take, prev_valid;
    out_beat_t   obs;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source models: present the head of each channel queue, retire on handshake.
    initial begin
        s_tvalid = '0; s_tdest = '0; s_tdata = '0; s_tlast = '0;
        foreach (mdl_cnt[i]) mdl_cnt[i] = '0;
        forever begin
            @(negedge clk);
            take = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (take[i] && src_q[i].size() > 0) begin
                    if (src_q[i][0].last) mdl_cnt[i] = mdl_cnt[i] + 32'd1;
                    void'(src_q[i].pop_front());
                end
            end
            prev_valid = s_tvalid;
            for (int i = 0; i < NUM_CH; i++) begin
                if (src_q[i].size() > 0) begin
                    s_tvalid[i] = 1'b1;
                    s_tdest[i*TDEST_W +: TDEST_W] = src_q[i][0].dest;
                    s_tdata[i*DATA_W +: DATA_W]   = src_q[i][0].data;
                    s_tlast[i] = src_q[i][0].last;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tdest[i*TDEST_W +: TDEST_W] = '0;
                    s_tdata[i*DATA_W +: DATA_W]   = '0;
                    s_tlast[i] = 1'b0;
                end
            end
            if (prev_valid == '0 && s_tvalid != '0) rise_cyc = cyc;
        end
    end

    // Output monitor: every valid cycle must show the scoreboard head.
    always @(negedge clk) begin
        if (rstn && m_tvalid) begin
            obs = '{src: m_tsrc, dest: m_tdest, data: m_tdata, last: m_tlast};
            if (!seen_valid) begin
                seen_valid = 1'b1;
                first_cyc  = cyc;
            end
            if (exp_q.size() == 0) begin
                check("extra_beat", 128'(obs), {1'b1, 127'b0});
            end else begin
                check("beat", 128'(obs), 128'(exp_q[0]));
                if (m_tready) begin
                    void'(exp_q.pop_front());
                    out_cnt++;
                    if (chk_gap && have_prev) check("gap", cyc - prev_out_cyc, 2);
                    have_prev    = 1'b1;
                    prev_out_cyc = cyc;
                end
            end
        end
    end

    task automatic send(input int ch, input int n, input logic [TDEST_W-1:0] dest, input logic [DATA_W-1:0] base);
        for (int b = 0; b < n; b++)
            src_q[ch].push_back(src_beat_t'{dest: dest, data: base + DATA_W'(b), last: (b == n - 1)});
    endtask

    task automatic expect_pkt(input int ch, input int n, input logic [TDEST_W-1:0] dest, input logic [DATA_W-1:0] base);
        for (int b = 0; b < n; b++)
            exp_q.push_back(out_beat_t'{src: CH_W'(ch), dest: dest, data: base + DATA_W'(b), last: (b == n - 1)});
    endtask

    task automatic start_test();
        @(posedge clk);
        #3;
        out_cnt = 0; seen_valid = 0; have_prev = 0; chk_gap = 0;
    endtask

    task automatic wait_out(input int target, input int budget, input string tag);
        int k = 0;
        while (out_cnt < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (out_cnt < target) check({tag, "_timeout"}, out_cnt, target);
    endtask

    task automatic end_test(input int target, input string tag);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check({tag, "_count"}, out_cnt, target);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rstn = 1'b0;
        for (int i = 0; i < NUM_CH; i++) src_q[i].delete();
        exp_q.delete();
        foreach (mdl_cnt[i]) mdl_cnt[i] = '0;
        @(negedge clk);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_fields", {m_tdest, m_tdata, m_tlast, m_tsrc}, 0);
`ifdef MERGER_STATS_EN
        check("rst_pkt_cnt", pkt_cnt, 0);
`endif
        @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // Single channel, 3 beats
        start_test();
        send(2, 3, 4'd5, 64'hA0);
        expect_pkt(2, 3, 4'd5, 64'hA0);
        wait_out(3, 30, "single");
        check("single_latency", first_cyc - rise_cyc, 2);
        check("single_burst", prev_out_cyc - first_cyc, 2);
        end_test(3, "single");
        check("single_idle_tready", s_tready, 0);

        // Fairness: all channels valid, 1-beat packets
        do_reset();
        start_test();
        chk_gap = 1;
        for (int k = 0; k < 3; k++)
            for (int ch = 0; ch < NUM_CH; ch++) begin
                send(ch, 1, TDEST_W'(ch), 64'h100 * (ch + 1) + k);
                expect_pkt(ch, 1, TDEST_W'(ch), 64'h100 * (ch + 1) + k);
            end
        wait_out(12, 100, "fair");
        end_test(12, "fair");

        // No interleave: ch1 joins while ch0 packet is in flight
        start_test();
        send(0, 4, 4'd1, 64'hC0);
        expect_pkt(0, 4, 4'd1, 64'hC0);
        expect_pkt(1, 2, 4'd2, 64'hD0);
        for (int k = 0; k < 50 && src_q[0].size() > 2; k++) begin
            @(posedge clk);
            #3;
        end
        send(1, 2, 4'd2, 64'hD0);
        wait_out(6, 60, "nointlv");
        end_test(6, "nointlv");

        // Backpressure: m_tready 1,0,0,1 from the first output beat
        start_test();
        send(1, 3, 4'd3, 64'hE0);
        expect_pkt(1, 3, 4'd3, 64'hE0);
        for (int k = 0; k < 30 && !m_tvalid; k++) @(negedge clk);
        check("bp_valid_seen", m_tvalid, 1);
        for (int p = 0; p < 2; p++) begin
            @(posedge clk);
            #1;
            m_tready = 1'b0;
            @(negedge clk);
            check("bp_stall_tready", s_tready, 0);
            check("bp_stall_valid", m_tvalid, 1);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        wait_out(3, 30, "bp");
        end_test(3, "bp");

        // Reset mid-packet on ch3, then ch0 must beat ch3
        start_test();
        send(3, 3, 4'd7, 64'hF0);
        expect_pkt(3, 3, 4'd7, 64'hF0);
        wait_out(1, 30, "midrst");
        do_reset();
        start_test();
        send(3, 1, 4'd7, 64'h3F);
        send(0, 1, 4'd6, 64'h0F);
        expect_pkt(0, 1, 4'd6, 64'h0F);
        expect_pkt(3, 1, 4'd7, 64'h3F);
        wait_out(2, 30, "postrst");
        end_test(2, "postrst");

`ifdef MERGER_STATS_EN
        for (int i = 0; i < NUM_CH; i++) check("pkt_cnt", pkt_cnt[i*32 +: 32], mdl_cnt[i]);
        force dut.g_pkt_cnt[1].r_cnt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.g_pkt_cnt[1].r_cnt;
        mdl_cnt[1] = 32'hFFFF_FFFF;
        start_test();
        send(1, 2, 4'd1, 64'h55);
        expect_pkt(1, 2, 4'd1, 64'h55);
        wait_out(2, 30, "stats");
        end_test(2, "stats");
        check("pkt_cnt_wrap", pkt_cnt[63:32], 0);
        for (int i = 0; i < NUM_CH; i++) check("pkt_cnt_after", pkt_cnt[i*32 +: 32], mdl_cnt[i]);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
